// File: rtl/mul_sched.sv
// Two-requester front end sharing one iterative shift-add unsigned multiplier.
// Round-robin grant, one add/shift step per cycle, tagged result over valid/ready.
module mul_sched #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_id,
  output logic [2*WIDTH-1:0] res,
  output logic               busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic               last;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic               grant;
  logic               hs;

  // One shift-add step: the carry out of the upper-half add lands in the MSB after the shift.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc_in,
                                                  input logic [WIDTH-1:0]   b_in,
                                                  input logic               bit_in);
    logic [WIDTH:0]     sum;
    logic [2*WIDTH:0]   wide;
    sum  = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (bit_in ? {1'b0, b_in} : '0);
    wide = {sum, acc_in[WIDTH-1:0]};
    return wide[2*WIDTH:1];
  endfunction

  always_comb begin
    grant = req_valid[1];
    if (req_valid == 2'b11) grant = ~last;
    req_ready = 2'b00;
    if (state == IDLE && req_valid[grant]) req_ready = grant ? 2'b10 : 2'b01;
  end

  assign hs       = |(req_valid & req_ready);
  assign acc_next = mul_step(acc, b_q, a_q[cnt]);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      cnt       <= '0;
      res_valid <= 1'b0;
      res_id    <= 1'b0;
      res       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hs) begin
            cnt   <= '0;
            last  <= grant;
            state <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            res       <= acc_next;
            res_id    <= last;
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand and accumulator registers carry no reset; they are always loaded on accept.
  always_ff @(posedge clk) begin
    if (state == IDLE && hs) begin
      a_q <= grant ? a1 : a0;
      b_q <= grant ? b1 : b0;
      acc <= '0;
    end else if (state == RUN) begin
      acc <= acc_next;
    end
  end

endmodule

// File: tb/tb_mul_sched.sv
// Directed bench for mul_sched: scoreboard of expected {id, product} pushed on accept,
// popped and compared when a result appears; latency, arbitration and stall checks.
module tb_mul_sched;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [W-1:0]   a0, b0, a1, b1;
  logic           res_valid, res_ready, res_id, busy;
  logic [2*W-1:0] res;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [2*W:0] sb[$];

  mul_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
    .res(res), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [2*W:0] obs, input logic [2*W:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for a grant (bounded), checks it went to id, pushes the expected result.
  task automatic wait_accept(input int id, input int max, output int edge_n);
    bit found = 0;
    logic [2*W-1:0] prod;
    edge_n = 0;
    for (int i = 0; i < max; i++) begin
      if (req_ready != 2'b00) begin
        found = 1;
        break;
      end
      step_clk();
    end
    check("accept_seen", {64'd0, found}, 65'd1);
    if (found) begin
      check("grant", {63'd0, req_ready}, (id == 1) ? 65'd2 : 65'd1);
      prod = (id == 1) ? (64'(a1) * 64'(b1)) : (64'(a0) * 64'(b0));
      sb.push_back({id[0], prod});
      edge_n = cyc + 1;
    end
  endtask

  task automatic wait_result(input int max, input int acc_edge);
    bit found = 0;
    logic [2*W:0] exp;
    for (int i = 0; i < max; i++) begin
      if (res_valid) begin
        found = 1;
        break;
      end
      step_clk();
    end
    check("result_seen", {64'd0, found}, 65'd1);
    if (found) begin
      check("latency", 65'(cyc - acc_edge), 65'(W));
      check("sb_nonempty", 65'(sb.size() > 0), 65'd1);
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        check("res_id", {64'd0, res_id}, {64'd0, exp[2*W]});
        check("res", {1'b0, res}, {1'b0, exp[2*W-1:0]});
      end
    end
  endtask

  // Single request from one requester with res_ready high; valid dropped mid-RUN.
  task automatic run_op(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    int e;
    logic [2*W-1:0] prod;
    prod = 64'(a) * 64'(b);
    if (id == 1) begin a1 = a; b1 = b; end else begin a0 = a; b0 = b; end
    req_valid = (id == 1) ? 2'b10 : 2'b01;
    #1;
    wait_accept(id, 5, e);
    step_clk();
    check("ready_drop", {63'd0, req_ready}, 65'd0);
    check("busy_run", {64'd0, busy}, 65'd1);
    req_valid = 2'b00;
    wait_result(W + 5, e);
    step_clk();
    check("res_valid_drop", {64'd0, res_valid}, 65'd0);
    check("busy_idle", {64'd0, busy}, 65'd0);
    check("res_retained", {1'b0, res}, {1'b0, prod});
  endtask

  initial begin
    int e, prev;
    rst = 1'b1; req_valid = 2'b00; res_ready = 1'b1;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    step_clk();
    step_clk();
    check("rst_res_valid", {64'd0, res_valid}, 65'd0);
    check("rst_res_id", {64'd0, res_id}, 65'd0);
    check("rst_res", {1'b0, res}, 65'd0);
    check("rst_busy", {64'd0, busy}, 65'd0);
    check("rst_req_ready", {63'd0, req_ready}, 65'd0);
    rst = 1'b0;
    step_clk();

    run_op(0, 32'd3, 32'd5);
    run_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Both requesters held valid: grants must alternate starting with 0.
    a0 = 32'd7; b0 = 32'd6; a1 = 32'd0; b1 = 32'd9;
    req_valid = 2'b11; res_ready = 1'b1;
    #1;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_accept(k % 2, W + 8, e);
      if (k > 0) check("accept_spacing", 65'(e - prev), 65'(W + 2));
      prev = e;
      step_clk();
      wait_result(W + 5, e);
    end
    step_clk();

    // Stalled consumer: result and id must hold; no accepts while DONE.
    res_ready = 1'b0;
    wait_accept(0, 5, e);
    step_clk();
    wait_result(W + 5, e);
    for (int i = 0; i < 10; i++) begin
      step_clk();
      check("stall_valid", {64'd0, res_valid}, 65'd1);
      check("stall_res", {1'b0, res}, 65'd42);
      check("stall_id", {64'd0, res_id}, 65'd0);
      check("stall_ready", {63'd0, req_ready}, 65'd0);
    end
    res_ready = 1'b1;
    step_clk();
    wait_accept(1, 1, e);
    step_clk();
    req_valid = 2'b00;
    wait_result(W + 5, e);
    step_clk();

    // Reset in the middle of RUN discards the operation.
    a0 = 32'd1234; b0 = 32'd5678; req_valid = 2'b01;
    #1;
    wait_accept(0, 5, e);
    step_clk();
    req_valid = 2'b00;
    for (int i = 0; i < 14; i++) step_clk();
    rst = 1'b1;
    step_clk();
    rst = 1'b0;
    sb.delete();
    check("abort_busy", {64'd0, busy}, 65'd0);
    check("abort_res_valid", {64'd0, res_valid}, 65'd0);
    check("abort_res", {1'b0, res}, 65'd0);
    run_op(0, 32'd2, 32'd2);

    run_op(1, 32'd0, 32'hDEAD_BEEF);
    run_op(0, 32'h8000_0000, 32'd2);
    for (int i = 0; i < 4; i++) run_op(i % 2, W'($urandom), W'($urandom));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
